// File: rtl/bcd_seg_display_if.sv
// Signal bundle between the upstream 0..99 counter stage and the two-digit
// seven-segment display converter.
interface bcd_seg_display_if;
    // Protocol: no handshake. The master holds i_num at the value to show; the
    // slave converts whenever it is idle and i_num differs from the last
    // captured value, keeps o_busy high for the whole conversion, and pulses
    // o_upd for one cycle together with the new segment values.
    logic [7:0] i_num;
    logic [7:0] o_seg_hi;
    logic [7:0] o_seg_lo;
    logic       o_busy;
    logic       o_upd;
    logic [1:0] o_state;

    modport master (
        output i_num,
        input  o_seg_hi, o_seg_lo, o_busy, o_upd, o_state
    );

    modport slave (
        input  i_num,
        output o_seg_hi, o_seg_lo, o_busy, o_upd, o_state
    );
endinterface

// File: rtl/bcd_seg_display.sv
// Binary (0..MAX_NUM) to two-digit active-low seven-segment converter using a
// sequential double-dabble. Define SEG_BLANK_LZ_EN to blank a leading zero tens digit.
module bcd_seg_display #(
    parameter int MAX_NUM = 99
) (
    input  logic              i_clk,
    input  logic              i_rst,
    bcd_seg_display_if.slave  bus
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CONV = 2'd1;
    localparam logic [1:0] S_LOAD = 2'd2;

    localparam logic [7:0] SEG_BLANK = 8'hFF;
    localparam logic [7:0] MAX_VAL   = 8'(MAX_NUM);

`ifdef SEG_BLANK_LZ_EN
    localparam logic BLANK_LZ = 1'b1;
`else
    localparam logic BLANK_LZ = 1'b0;
`endif

    // Segment order {dp,g,f,e,d,c,b,a}, active-low, dp always off.
    function automatic logic [7:0] seg_decode(input logic [3:0] d);
        case (d)
            4'd0:    seg_decode = 8'hC0;
            4'd1:    seg_decode = 8'hF9;
            4'd2:    seg_decode = 8'hA4;
            4'd3:    seg_decode = 8'hB0;
            4'd4:    seg_decode = 8'h99;
            4'd5:    seg_decode = 8'h92;
            4'd6:    seg_decode = 8'h82;
            4'd7:    seg_decode = 8'hF8;
            4'd8:    seg_decode = 8'h80;
            4'd9:    seg_decode = 8'h90;
            default: seg_decode = SEG_BLANK;
        endcase
    endfunction

    function automatic logic [7:0] hi_decode(input logic [3:0] d);
        if (BLANK_LZ && (d == 4'd0)) hi_decode = SEG_BLANK;
        else                         hi_decode = seg_decode(d);
    endfunction

    logic [1:0]  r_state;
    logic [7:0]  r_last;
    logic [7:0]  r_op;
    logic [7:0]  r_bcd;
    logic [2:0]  r_cnt;
    logic [7:0]  r_seg_hi;
    logic [7:0]  r_seg_lo;
    logic        r_upd;

    logic [7:0]  w_sat;
    logic [7:0]  w_adj_bcd;
    logic [15:0] w_shift;

    assign w_sat = (bus.i_num > MAX_VAL) ? MAX_VAL : bus.i_num;

    always_comb begin
        w_adj_bcd = r_bcd;
        if (r_bcd[3:0] >= 4'd5) w_adj_bcd[3:0] = r_bcd[3:0] + 4'd3;
        if (r_bcd[7:4] >= 4'd5) w_adj_bcd[7:4] = r_bcd[7:4] + 4'd3;
        // The bit shifted out of the top is the hundreds carry, dropped here.
        w_shift = {w_adj_bcd, r_op} << 1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state  <= S_IDLE;
            r_last   <= 8'd0;
            r_op     <= 8'd0;
            r_bcd    <= 8'd0;
            r_cnt    <= 3'd0;
            r_seg_hi <= hi_decode(4'd0);
            r_seg_lo <= seg_decode(4'd0);
            r_upd    <= 1'b0;
        end else begin
            r_upd <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_num != r_last) begin
                        r_op    <= w_sat;
                        r_last  <= bus.i_num;
                        r_bcd   <= 8'd0;
                        r_cnt   <= 3'd0;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    r_bcd <= w_shift[15:8];
                    r_op  <= w_shift[7:0];
                    r_cnt <= r_cnt + 3'd1;
                    if (r_cnt == 3'd7) r_state <= S_LOAD;
                end
                S_LOAD: begin
                    r_seg_hi <= hi_decode(r_bcd[7:4]);
                    r_seg_lo <= seg_decode(r_bcd[3:0]);
                    r_upd    <= 1'b1;
                    r_state  <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_seg_hi = r_seg_hi;
    assign bus.o_seg_lo = r_seg_lo;
    assign bus.o_busy   = (r_state != S_IDLE);
    assign bus.o_upd    = r_upd;
    assign bus.o_state  = r_state;

endmodule

// File: tb/tb_bcd_seg_display.sv
// Directed self-checking bench for bcd_seg_display: reset state, conversions,
// saturation, input change mid-conversion, and reset abort.
module tb_bcd_seg_display;

`ifdef SEG_BLANK_LZ_EN
    localparam logic [7:0] EXP_HI0 = 8'hFF;
`else
    localparam logic [7:0] EXP_HI0 = 8'hC0;
`endif

    logic i_clk;
    logic i_rst;
    int   n_checks;
    int   n_fail;

    bcd_seg_display_if bus ();

    bcd_seg_display #(.MAX_NUM(99)) dut (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .bus   (bus.slave)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Full conversion from the capture edge: busy for 9 cycles, then one o_upd pulse.
    task automatic do_conv(input string tag, input logic [7:0] num,
                           input logic [7:0] exp_hi, input logic [7:0] exp_lo);
        int busy_cnt;
        int upd_cnt;
        busy_cnt  = 0;
        upd_cnt   = 0;
        bus.i_num = num;
        for (int k = 1; k <= 9; k++) begin
            tick();
            if (bus.o_busy) busy_cnt++;
            if (bus.o_upd)  upd_cnt++;
        end
        check_val({tag, "_busy_cycles"}, busy_cnt, 9);
        check_val({tag, "_early_upd"}, upd_cnt, 0);
        tick();
        check_val({tag, "_upd"}, bus.o_upd, 1'b1);
        check_val({tag, "_busy_done"}, bus.o_busy, 1'b0);
        check_val({tag, "_hi"}, bus.o_seg_hi, exp_hi);
        check_val({tag, "_lo"}, bus.o_seg_lo, exp_lo);
        tick();
        check_val({tag, "_upd_single"}, bus.o_upd, 1'b0);
    endtask

    initial begin
        int upd_cnt;
        int busy_cnt;
        n_checks  = 0;
        n_fail    = 0;
        i_rst     = 1'b1;
        bus.i_num = 8'd0;
        tick();
        tick();
        check_val("rst_hi", bus.o_seg_hi, EXP_HI0);
        check_val("rst_lo", bus.o_seg_lo, 8'hC0);
        check_val("rst_busy", bus.o_busy, 1'b0);
        check_val("rst_upd", bus.o_upd, 1'b0);
        i_rst = 1'b0;

        // i_num equal to the reset r_last value: nothing happens.
        upd_cnt  = 0;
        busy_cnt = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.o_upd)  upd_cnt++;
            if (bus.o_busy) busy_cnt++;
        end
        check_val("idle0_upd", upd_cnt, 0);
        check_val("idle0_busy", busy_cnt, 0);
        check_val("idle0_hi", bus.o_seg_hi, EXP_HI0);

        do_conv("n42", 8'd42, 8'h99, 8'hA4);
        do_conv("n150", 8'd150, 8'h90, 8'h90);
        do_conv("n100", 8'd100, 8'h90, 8'h90);
        do_conv("n10", 8'd10, 8'hF9, 8'hC0);
        do_conv("n7", 8'd7, EXP_HI0, 8'hF8);
        do_conv("n0", 8'd0, EXP_HI0, 8'hC0);

        // 12, then 57 during CONV: 12 shown first, then a second conversion for 57.
        bus.i_num = 8'd12;
        upd_cnt   = 0;
        for (int k = 1; k <= 24; k++) begin
            tick();
            if (k == 4) bus.i_num = 8'd57;
            if (bus.o_upd) upd_cnt++;
            if (k == 10) begin
                check_val("chg_upd1", bus.o_upd, 1'b1);
                check_val("chg_hi1", bus.o_seg_hi, 8'hF9);
                check_val("chg_lo1", bus.o_seg_lo, 8'hA4);
            end
            if (k == 11) check_val("chg_recapture_busy", bus.o_busy, 1'b1);
            if (k == 20) begin
                check_val("chg_upd2", bus.o_upd, 1'b1);
                check_val("chg_hi2", bus.o_seg_hi, 8'h92);
                check_val("chg_lo2", bus.o_seg_lo, 8'hF8);
            end
        end
        check_val("chg_upd_count", upd_cnt, 2);

        // Reset at CONV edge 4 of 88 aborts; conversion restarts afterwards.
        bus.i_num = 8'd88;
        tick();
        for (int k = 1; k <= 4; k++) tick();
        check_val("abort_busy_pre", bus.o_busy, 1'b1);
        i_rst = 1'b1;
        tick();
        check_val("abort_busy", bus.o_busy, 1'b0);
        check_val("abort_upd", bus.o_upd, 1'b0);
        check_val("abort_hi", bus.o_seg_hi, EXP_HI0);
        check_val("abort_lo", bus.o_seg_lo, 8'hC0);
        i_rst = 1'b0;
        tick();
        check_val("restart_busy", bus.o_busy, 1'b1);
        upd_cnt = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (bus.o_upd) upd_cnt++;
        end
        check_val("restart_early_upd", upd_cnt, 0);
        tick();
        check_val("restart_upd", bus.o_upd, 1'b1);
        check_val("restart_hi", bus.o_seg_hi, 8'h80);
        check_val("restart_lo", bus.o_seg_lo, 8'h80);
        tick();
        check_val("restart_idle", bus.o_busy, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
